// File: rtl/dwt_lift_rowpair.sv
// Row-pair integer-lifting Haar stage: buffers the even row, emits one (s,d) per column as the odd row streams in.
// Output latency 1 cycle after each odd-row accept; output register holds under out_ready=0 and stalls input.
module dwt_lift_rowpair #(
  parameter int DATA_W = 8,
  parameter int LENGTH = 256,
  parameter int ROWS   = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_s,
  output logic [DATA_W:0]   out_d,
  output logic              busy,
  output logic              pair_done,
  output logic              frame_done
);

  localparam int COL_W = $clog2(LENGTH);
  localparam int RP_W  = (ROWS > 2) ? $clog2(ROWS / 2) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LENGTH - 1);
  localparam logic [RP_W-1:0]  RP_LAST  = RP_W'(ROWS / 2 - 1);

  typedef enum logic [1:0] {FILL, PAIR, DRAIN} state_t;

  state_t            state_q;
  logic [COL_W-1:0]  col_q;
  logic [RP_W-1:0]   row_pair_q;
  logic              mode_q;
  logic              rdy_en_q;
  logic              busy_q;
  logic              pair_done_q;
  logic              frame_done_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_s_q;
  logic [DATA_W:0]   out_d_q;
  logic [DATA_W-1:0] line_q [LENGTH];

  logic              accept;
  logic              out_take;
  logic [DATA_W-1:0] buf_rd;
  logic [DATA_W-1:0] pix_in;
  logic [DATA_W:0]   fwd_d;
  logic [DATA_W-1:0] fwd_s;
  logic [DATA_W-1:0] inv_b;
  logic [DATA_W-1:0] inv_a;
  logic [DATA_W-1:0] s_d;
  logic [DATA_W:0]   d_d;

  assign in_ready = rdy_en_q &&
                    ((state_q == FILL) || ((state_q == PAIR) && (!out_valid_q || out_ready)));
  assign accept   = in_valid && in_ready;
  assign out_take = out_valid_q && out_ready;

  assign buf_rd = line_q[col_q];
  assign pix_in = in_data[DATA_W-1:0];

  // Only the low DATA_W bits of s/a/b survive, so the floor-halving of d is just d[DATA_W:1] mod 2^DATA_W.
  assign fwd_d = {1'b0, buf_rd} - {1'b0, pix_in};
  assign fwd_s = pix_in + fwd_d[DATA_W:1];
  assign inv_b = buf_rd - in_data[DATA_W:1];
  assign inv_a = in_data[DATA_W-1:0] + inv_b;

  assign s_d = mode_q ? inv_a : fwd_s;
  assign d_d = mode_q ? {1'b0, inv_b} : fwd_d;

  always_ff @(posedge clk) begin
    if (state_q == FILL && accept) begin
      line_q[col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_pair_q   <= '0;
      mode_q       <= 1'b0;
      rdy_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      pair_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_s_q      <= '0;
      out_d_q      <= '0;
    end else begin
      rdy_en_q     <= 1'b1;
      pair_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (accept && !busy_q) begin
        busy_q <= 1'b1;
      end
      if (out_take) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          if (accept) begin
            if (col_q == '0) begin
              mode_q <= mode;
            end
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= PAIR;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        PAIR: begin
          if (accept) begin
            out_valid_q <= 1'b1;
            out_s_q     <= s_d;
            out_d_q     <= d_d;
            if (col_q == COL_LAST) begin
              col_q   <= '0;
              state_q <= DRAIN;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (!out_valid_q || out_take) begin
            pair_done_q <= 1'b1;
            state_q     <= FILL;
            if (row_pair_q == RP_LAST) begin
              frame_done_q <= 1'b1;
              busy_q       <= 1'b0;
              row_pair_q   <= '0;
            end else begin
              row_pair_q <= row_pair_q + RP_W'(1);
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_s      = out_s_q;
  assign out_d      = out_d_q;
  assign busy       = busy_q;
  assign pair_done  = pair_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_dwt_lift_rowpair.sv
// Bench for dwt_lift_rowpair: a 4x2 instance for directed vectors, an 8x8 instance for a random fwd/inv round trip.
module tb_dwt_lift_rowpair;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       a_mode, a_iv, a_ir, a_ov, a_or, a_busy, a_pd, a_fd;
  logic [8:0] a_id, a_od;
  logic [7:0] a_os;
  logic       b_mode, b_iv, b_ir, b_ov, b_busy, b_pd, b_fd;
  logic       b_or = 1'b1;
  logic [8:0] b_id, b_od;
  logic [7:0] b_os;
  logic       b_rr;

  dwt_lift_rowpair #(.DATA_W(8), .LENGTH(4), .ROWS(2)) u_a (
    .clk(clk), .reset(reset), .mode(a_mode), .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_s(a_os), .out_d(a_od),
    .busy(a_busy), .pair_done(a_pd), .frame_done(a_fd));

  dwt_lift_rowpair #(.DATA_W(8), .LENGTH(8), .ROWS(8)) u_b (
    .clk(clk), .reset(reset), .mode(b_mode), .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_s(b_os), .out_d(b_od),
    .busy(b_busy), .pair_done(b_pd), .frame_done(b_fd));

  typedef struct {int s; int d; bit last; bit flast;} exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   a_pd_exp, a_fd_exp, b_pd_exp, b_fd_exp;
  int   b_pd_cnt, b_fd_cnt;

  int s1_a[8] = '{255, 0, 10, 7, 0, 0, 0, 0};
  int s1_b[8] = '{0, 255, 10, 8, 0, 0, 0, 0};
  int s1_s[8] = '{127, 127, 10, 7, 0, 0, 0, 0};
  int s1_d[8] = '{255, -255, 0, -1, 0, 0, 0, 0};

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Reference model: plain Haar averages/differences with floor halving.
  function automatic int half_floor(int x);
    return (x >= 0) ? x / 2 : -((1 - x) / 2);
  endfunction
  function automatic int fwd_s(int a, int b); return (a + b) / 2; endfunction
  function automatic int fwd_d(int a, int b); return a - b; endfunction
  function automatic int inv_b(int s, int d); return (s - half_floor(d)) & 255; endfunction
  function automatic int inv_a(int s, int d); return (inv_b(s, d) + d) & 255; endfunction

  task automatic push(int u, int s, int d, bit last, bit fl);
    exp_t e;
    e.s = s; e.d = d; e.last = last; e.flast = fl;
    if (u != 0) qb.push_back(e);
    else qa.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic put(int u, int m, int x);
    logic [8:0] v;
    bit acc;
    bit ok;
    v = x[8:0];
    ok = 1'b0;
    if (u != 0) begin b_mode = m[0]; b_iv = 1'b1; b_id = v; end
    else        begin a_mode = m[0]; a_iv = 1'b1; a_id = v; end
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = (u != 0) ? b_ir : a_ir;
      @(posedge clk); #1;
      if (acc) begin ok = 1'b1; break; end
    end
    if (u != 0) b_iv = 1'b0;
    else        a_iv = 1'b0;
    if (!ok) chk("in_accept_timeout", 0, 1);
  endtask

  // Mode is driven to the opposite value on every sample but the row-pair's first.
  task automatic send_pair(int u, int n, int m, input int r0[8], input int r1[8], int gapmax);
    for (int c = 0; c < n; c++) begin
      put(u, (c == 0) ? m : 1 - m, r0[c]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
    for (int c = 0; c < n; c++) begin
      put(u, 1 - m, r1[c]);
      if (gapmax > 0) idle($urandom_range(0, gapmax));
    end
  endtask

  task automatic wait_drain(int u);
    for (int t = 0; t < 400; t++) begin
      if (((u != 0) ? qb.size() : qa.size()) == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", (u != 0) ? qb.size() : qa.size(), 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      qa.delete();
      a_pd_exp = 1'b0; a_fd_exp = 1'b0;
    end else begin
      if (a_ov) begin
        if (qa.size() == 0) chk("a_unexpected_out", 1, 0);
        else begin
          chk("a_out_s", int'(a_os), qa[0].s);
          chk("a_out_d", int'($signed(a_od)), qa[0].d);
        end
      end
      chk("a_pair_done", int'(a_pd), int'(a_pd_exp));
      chk("a_frame_done", int'(a_fd), int'(a_fd_exp));
      a_pd_exp = 1'b0; a_fd_exp = 1'b0;
      if (a_ov && a_or && qa.size() > 0) begin
        a_pd_exp = qa[0].last; a_fd_exp = qa[0].flast;
        void'(qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      qb.delete();
      b_pd_exp = 1'b0; b_fd_exp = 1'b0; b_pd_cnt = 0; b_fd_cnt = 0;
    end else begin
      if (b_ov) begin
        if (qb.size() == 0) chk("b_unexpected_out", 1, 0);
        else begin
          chk("b_out_s", int'(b_os), qb[0].s);
          chk("b_out_d", int'($signed(b_od)), qb[0].d);
        end
      end
      chk("b_pair_done", int'(b_pd), int'(b_pd_exp));
      chk("b_frame_done", int'(b_fd), int'(b_fd_exp));
      if (b_pd) b_pd_cnt++;
      if (b_fd) b_fd_cnt++;
      b_pd_exp = 1'b0; b_fd_exp = 1'b0;
      if (b_ov && b_or && qb.size() > 0) begin
        b_pd_exp = qb[0].last; b_fd_exp = qb[0].flast;
        void'(qb.pop_front());
      end
    end
  end

  always begin
    @(posedge clk); #1;
    b_or = b_rr ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic push_s1();
    for (int c = 0; c < 4; c++) push(0, s1_s[c], s1_d[c], c == 3, c == 3);
  endtask

  initial begin
    int px[8][8];
    int r0[8];
    int r1[8];
    reset = 1'b1;
    a_iv = 1'b0; a_id = '0; a_mode = 1'b0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_mode = 1'b0; b_rr = 1'b0;

    chk("model_fwd_s", fwd_s(255, 0), 127);
    chk("model_fwd_d", fwd_d(7, 8), -1);
    chk("model_inv_a", inv_a(127, -255), 0);
    chk("model_inv_b", inv_b(127, -255), 255);

    idle(3);
    chk("rst_in_ready", int'(a_ir), 0);
    chk("rst_out_valid", int'(a_ov), 0);
    chk("rst_out_s", int'(a_os), 0);
    chk("rst_out_d", int'(a_od), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_pulses", int'(a_pd) + int'(a_fd), 0);
    chk("rst_b_out_valid", int'(b_ov), 0);
    reset = 1'b0;
    idle(1);
    chk("in_ready_after_reset", int'(a_ir), 1);

    // Forward vectors; mode flips after col 0 and must be ignored.
    push_s1();
    send_pair(0, 4, 0, s1_a, s1_b, 0);
    chk("busy_mid_frame", int'(a_busy), 1);
    wait_drain(0);
    chk("busy_after_frame", int'(a_busy), 0);

    // Inverse of the forward results.
    for (int c = 0; c < 4; c++) push(0, s1_a[c], s1_b[c], c == 3, c == 3);
    send_pair(0, 4, 1, s1_s, s1_d, 0);
    wait_drain(0);

    // Output backpressure while column 1 is presented.
    push_s1();
    fork
      send_pair(0, 4, 0, s1_a, s1_b, 0);
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (a_ov && a_os == 8'd127 && a_od == 9'd255) break;
        end
        @(posedge clk); #1;
        a_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_out_valid", int'(a_ov), 1);
          chk("bp_out_s", int'(a_os), 127);
          chk("bp_out_d", int'($signed(a_od)), -255);
          chk("bp_in_ready", int'(a_ir), 0);
          @(posedge clk); #1;
        end
        a_or = 1'b1;
      end
    join
    wait_drain(0);

    // Reset after two odd-row samples, then a fresh frame.
    push_s1();
    for (int c = 0; c < 4; c++) put(0, (c == 0) ? 0 : 1, s1_a[c]);
    for (int c = 0; c < 2; c++) put(0, 1, s1_b[c]);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", int'(a_ov), 0);
    chk("midrst_busy", int'(a_busy), 0);
    chk("midrst_in_ready", int'(a_ir), 0);
    idle(2);
    reset = 1'b0;
    idle(1);
    push_s1();
    send_pair(0, 4, 0, s1_a, s1_b, 0);
    wait_drain(0);

    // Random 8x8 frame: forward, then inverse of the model's forward result.
    b_rr = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) px[r][c] = $urandom_range(0, 255);
    for (int rp = 0; rp < 4; rp++)
      for (int c = 0; c < 8; c++)
        push(1, fwd_s(px[2*rp][c], px[2*rp+1][c]), fwd_d(px[2*rp][c], px[2*rp+1][c]),
             c == 7, (c == 7) && (rp == 3));
    for (int rp = 0; rp < 4; rp++) begin
      for (int c = 0; c < 8; c++) begin r0[c] = px[2*rp][c]; r1[c] = px[2*rp+1][c]; end
      send_pair(1, 8, 0, r0, r1, 2);
    end
    wait_drain(1);
    chk("fwd_pair_done_count", b_pd_cnt, 4);
    chk("fwd_frame_done_count", b_fd_cnt, 1);
    chk("fwd_busy_end", int'(b_busy), 0);

    for (int rp = 0; rp < 4; rp++)
      for (int c = 0; c < 8; c++)
        push(1, px[2*rp][c], px[2*rp+1][c], c == 7, (c == 7) && (rp == 3));
    for (int rp = 0; rp < 4; rp++) begin
      for (int c = 0; c < 8; c++) begin
        r0[c] = fwd_s(px[2*rp][c], px[2*rp+1][c]);
        r1[c] = fwd_d(px[2*rp][c], px[2*rp+1][c]);
      end
      send_pair(1, 8, 1, r0, r1, 2);
    end
    wait_drain(1);
    chk("inv_pair_done_count", b_pd_cnt, 8);
    chk("inv_frame_done_count", b_fd_cnt, 2);
    b_rr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
